// File: rtl/lcd_char_feeder.sv
// lcd_char_feeder: buffers ASCII chars and emits HD44780 command/data bytes over req/ack.
// Define LCD_FEEDER_CTRL_CHAR_EN to consume LF/CR at the FIFO head as cursor moves.
module lcd_char_feeder #(
    parameter int         COLS       = 16,
    parameter int         ROWS       = 2,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] LINE2_BASE = 8'h40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          char_valid,
    input  logic [7:0]                    char_data,
    output logic                          char_ready,
    input  logic                          clear_req,
    output logic                          lcd_req,
    output logic                          lcd_rs,
    output logic [7:0]                    lcd_byte,
    input  logic                          lcd_ack,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CLEAR, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            req_q, req_d, rs_q, rs_d;
    logic [7:0]      byte_q, byte_d;
    logic            row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            need_addr_q, need_addr_d;
    logic            clear_pending_q, clear_pending_d;
    logic            push, pop, is_lf, is_cr, row_next;
    logic [7:0]      head, addr;

    assign char_ready = count_q != FULL;
    assign push       = char_valid & char_ready & ~clear_req;
    assign head       = mem_q[rd_ptr_q];
    assign row_next   = (ROWS == 2) ? ~row_q : 1'b0;
    assign addr       = 8'h80 | ((row_q ? LINE2_BASE : 8'h00) + 8'(col_q));
    assign lcd_req    = req_q;
    assign lcd_rs     = rs_q;
    assign lcd_byte   = byte_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0) || clear_pending_q;

`ifdef LCD_FEEDER_CTRL_CHAR_EN
    assign is_lf = head == 8'h0A;
    assign is_cr = head == 8'h0D;
`else
    assign is_lf = 1'b0;
    assign is_cr = 1'b0;
`endif

    // A clear flushes the FIFO and wins over any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (clear_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        rs_d            = rs_q;
        byte_d          = byte_q;
        row_d           = row_q;
        col_d           = col_q;
        need_addr_d     = need_addr_q;
        clear_pending_d = clear_pending_q | clear_req;
        pop             = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_pending_q) state_d = S_CLEAR;
                else if (count_q != '0) begin
                    if (is_lf || is_cr) begin
                        pop         = 1'b1;
                        col_d       = '0;
                        need_addr_d = 1'b1;
                        row_d       = is_lf ? row_next : row_q;
                    end else state_d = need_addr_q ? S_ADDR : S_DATA;
                end
            end
            S_ADDR, S_DATA, S_CLEAR: begin
                // A clear arriving before the byte is offered abandons it; once offered it is held until acked.
                if (!req_q) begin
                    if (clear_pending_q && state_q != S_CLEAR) state_d = S_IDLE;
                    else begin
                        req_d  = 1'b1;
                        rs_d   = state_q == S_DATA;
                        byte_d = (state_q == S_DATA) ? head : (state_q == S_ADDR) ? addr : 8'h01;
                    end
                end else if (lcd_ack) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                    if (state_q == S_ADDR) begin
                        need_addr_d = 1'b0;
                        if (!clear_pending_q) state_d = S_DATA;
                    end else if (state_q == S_DATA) begin
                        pop = !clear_pending_q;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d       = '0;
                            row_d       = row_next;
                            need_addr_d = 1'b1;
                        end else col_d = col_q + CW'(1);
                    end else begin
                        row_d           = 1'b0;
                        col_d           = '0;
                        need_addr_d     = 1'b1;
                        clear_pending_d = clear_req;
                    end
                end
            end
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= char_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            req_q           <= 1'b0;
            rs_q            <= 1'b0;
            byte_q          <= 8'h00;
            row_q           <= 1'b0;
            col_q           <= '0;
            need_addr_q     <= 1'b1;
            clear_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            req_q           <= req_d;
            rs_q            <= rs_d;
            byte_q          <= byte_d;
            row_q           <= row_d;
            col_q           <= col_d;
            need_addr_q     <= need_addr_d;
            clear_pending_q <= clear_pending_d;
        end
    end
endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb_lcd_char_feeder: randomized bench comparing the emitted byte stream with a cursor model.
module tb_lcd_char_feeder;
    localparam int COLS  = 16;
    localparam int ROWS  = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, char_valid, char_ready, clear_req, lcd_req, lcd_rs, lcd_ack, busy;
    logic [7:0] char_data, lcd_byte;
    logic [4:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         m_row, m_col;
    bit         m_need;
    bit         ack_en, rand_ack;

    lcd_char_feeder #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH), .LINE2_BASE(8'h40)) dut (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .clear_req(clear_req), .lcd_req(lcd_req), .lcd_rs(lcd_rs),
        .lcd_byte(lcd_byte), .lcd_ack(lcd_ack), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_row  = 0;
        m_col  = 0;
        m_need = 1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_char(input logic [7:0] b);
`ifdef LCD_FEEDER_CTRL_CHAR_EN
        if (b == 8'h0A || b == 8'h0D) begin
            if (b == 8'h0A) m_row = (m_row + 1) % ROWS;
            m_col  = 0;
            m_need = 1;
            return;
        end
`endif
        if (m_need) begin
            exp_q.push_back({1'b0, 8'h80 | 8'((m_row == 1 ? 8'h40 : 0) + m_col)});
            m_need = 0;
        end
        exp_q.push_back({1'b1, b});
        m_col++;
        if (m_col == COLS) begin
            m_col  = 0;
            m_row  = (m_row + 1) % ROWS;
            m_need = 1;
        end
    endtask

    // Write-engine stand-in: acks after a delay, logs bytes, checks hold and the low gap after ack.
    initial begin : acker
        int         cnt;
        int         dly;
        bit         acked;
        logic [8:0] first;
        lcd_ack = 1'b0;
        cnt     = 0;
        dly     = 3;
        acked   = 0;
        first   = '0;
        forever begin
            @(negedge clk);
            lcd_ack = 1'b0;
            if (rst) begin
                cnt   = 0;
                acked = 0;
            end else begin
                if (acked) begin
                    checks++;
                    if (lcd_req !== 1'b0) begin
                        errors++;
                        $display("FAIL req_gap lcd_req=%b want 0", lcd_req);
                    end
                end
                acked = 0;
                if (lcd_req && ack_en) begin
                    if (cnt == 0) first = {lcd_rs, lcd_byte};
                    cnt++;
                    if (cnt >= dly) begin
                        if (cnt > 1) begin
                            checks++;
                            if ({lcd_rs, lcd_byte} !== first) begin
                                errors++;
                                $display("FAIL req_hold got %h want %h", {lcd_rs, lcd_byte}, first);
                            end
                        end
                        lcd_ack = 1'b1;
                        obs_q.push_back({lcd_rs, lcd_byte});
                        cnt   = 0;
                        acked = 1;
                        dly   = rand_ack ? int'($urandom_range(1, 4)) : 3;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = b;
        while (!char_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 char_valid = 1'b0;
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout char_ready=%b want 1", char_ready);
        end else model_char(b);
    endtask

    task automatic drain(input string name);
        int quiet = 0;
        for (int i = 0; i < 4000 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = (!busy && !lcd_req) ? quiet + 1 : 0;
        end
        if (quiet < 3) begin
            checks++;
            errors++;
            $display("FAIL %s_drain busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({lcd_req, lcd_rs, lcd_byte, fifo_count, char_ready, busy} !== {1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_in got req%b rs%b byte%h cnt%0d rdy%b busy%b want 0 0 00 0 1 0",
                     lcd_req, lcd_rs, lcd_byte, fifo_count, char_ready, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_req, fifo_count, char_ready, busy} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_out got req%b cnt%0d rdy%b busy%b want 0 0 1 0", lcd_req, fifo_count, char_ready, busy);
        end
        model_reset();
    endtask

    task automatic test_basic();
        rand_ack = 0;
        ack_en   = 1;
        push(8'h48);
        drain("basic");
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL basic_len got %0d want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 9'h080) begin
                errors++;
                $display("FAIL basic_addr got %h want 080", obs_q[0]);
            end
            checks++;
            if (obs_q[1] !== 9'h148) begin
                errors++;
                $display("FAIL basic_data got %h want 148", obs_q[1]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = 8'h69;
        @(posedge clk);
        #1 char_valid = 1'b0;
        model_char(8'h69);
        @(posedge clk);
        #1;
        checks++;
        if (lcd_req !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge1 lcd_req=%b want 0", lcd_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({lcd_req, lcd_rs, lcd_byte} !== {1'b1, 1'b1, 8'h69}) begin
            errors++;
            $display("FAIL latency_edge2 got req%b rs%b %h want 1 1 69", lcd_req, lcd_rs, lcd_byte);
        end
        drain("latency");
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q[obs_q.size()-1] !== 9'h169) begin
            errors++;
            $display("FAIL latency_stream got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rand_ack = 1;
        for (int i = 0; i < 33; i++) push(i < 17 ? 8'(8'h41 + i) : 8'($urandom_range(32, 126)));
        drain("wrap");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wrap_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_byte[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 36) begin
            checks++;
            if (obs_q[17] !== 9'h0C0 || obs_q[34] !== 9'h080) begin
                errors++;
                $display("FAIL wrap_addr got %h %h want 0c0 080", obs_q[17], obs_q[34]);
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] b;
        do_reset();
        ack_en = 0;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(32, 126));
            @(negedge clk);
            char_valid = 1'b1;
            char_data  = b;
            if (i < DEPTH) model_char(b);
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_count, char_ready, lcd_req, busy} !== {5'd16, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL full_state got cnt%0d rdy%b req%b busy%b want 16 0 1 1", fifo_count, char_ready, lcd_req, busy);
        end
        ack_en   = 1;
        rand_ack = 1;
        drain("full");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_byte[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        int n = 0;
        do_reset();
        rand_ack = 0;
        for (int i = 0; i < 6; i++) push(8'(8'h41 + i));
        exp_q.delete();
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h141);
        exp_q.push_back(9'h142);
        exp_q.push_back(9'h001);
        while (!(lcd_req && lcd_rs && lcd_byte == 8'h42) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fifo_count !== 5'd5) begin
            errors++;
            $display("FAIL clear_queued got %0d want 5", fifo_count);
        end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        checks++;
        if ({fifo_count, lcd_req, lcd_byte, busy} !== {5'd0, 1'b1, 8'h42, 1'b1}) begin
            errors++;
            $display("FAIL clear_flush got cnt%0d req%b %h busy%b want 0 1 42 1", fifo_count, lcd_req, lcd_byte, busy);
        end
        drain("clear");
        m_row  = 0;
        m_col  = 0;
        m_need = 1;
        push(8'h5A);
        drain("clear_after");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL clear_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clear_byte[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_ctrl();
        logic [8:0] want [4];
`ifdef LCD_FEEDER_CTRL_CHAR_EN
        want = '{9'h080, 9'h158, 9'h0C0, 9'h159};
`else
        want = '{9'h080, 9'h158, 9'h10A, 9'h159};
`endif
        do_reset();
        rand_ack = 1;
        push(8'h58);
        push(8'h0A);
        push(8'h59);
        drain("ctrl");
        checks++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            errors++;
            $display("FAIL ctrl_len got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i] !== want[i] || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ctrl_byte[%0d] got %h want %h", i, obs_q[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        rand_ack = 1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = int'($urandom_range(0, 7));
            push(r == 0 ? 8'h0A : r == 1 ? 8'h0D : 8'($urandom_range(32, 126)));
        end
        drain("random");
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_len got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_byte[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        do_reset();
        rand_ack = 0;
        ack_en   = 1;
        push(8'h4D);
        push(8'h4E);
        while (!(lcd_req && lcd_rs) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ack_en = 0;
        checks++;
        if ({lcd_req, lcd_rs, lcd_byte} !== {1'b1, 1'b1, 8'h4D}) begin
            errors++;
            $display("FAIL rstmid_pre got req%b rs%b %h want 1 1 4d", lcd_req, lcd_rs, lcd_byte);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({lcd_req, fifo_count, char_ready, busy} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async got req%b cnt%0d rdy%b busy%b want 0 0 1 0", lcd_req, fifo_count, char_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({lcd_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_after got req%b busy%b want 0 0", lcd_req, busy);
        end
        ack_en = 1;
    endtask

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        clear_req  = 1'b0;
        ack_en     = 1;
        rand_ack   = 0;
        model_reset();
        test_reset();
        test_basic();
        test_latency();
        test_wrap();
        test_full();
        test_clear();
        test_ctrl();
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
